// File: rtl/regfile_mreg_sequencer.sv
// rtl/regfile_mreg_sequencer.sv - LDM/STM multiple-register transfer sequencer
//
// Purpose: walks a 16-bit register list in ascending order and moves one
// word per listed register between the 16x32 register file and memory.
// Stores read the register file through port B (RfRdSel/RfRdData) and issue
// memory writes. Loads issue memory reads and write the returned word through
// the C port (RfWrSel/RfWrData/RfLd). Memory uses a MemReq/MemAck handshake.
// A request completes on the rising edge where MemReq and MemAck are both 1.
//
// Optional feature macro: MREG_WRITEBACK_EN. When it is defined, the updated
// base address is written back to BaseReg after the last transfer.
//
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Start               launch a transfer (sampled only in IDLE)
//   IsLoad, Up          1 = LDM / 0 = STM; 1 = increment-after / 0 = decrement-before
//   RegList, BaseIn     register list and base address (captured on Start)
//   BaseReg             base register number (writeback feature only)
//   RfRdSel, RfRdData   register-file port B select and read data
//   RfWrSel, RfWrData   register-file write select and write data
//   RfLd                register-file write enable
//   MemReq, MemWr       memory request; 1 = write, 0 = read
//   MemAddr, MemWrData  word address and store data
//   MemRdData, MemAck   load data and request acknowledge
//   Busy, Done          1 outside IDLE; one-cycle completion pulse

module regfile_mreg_sequencer #(
  parameter int DW   = 32,
  parameter int STEP = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          IsLoad,
  input  logic          Up,
  input  logic [15:0]   RegList,
  input  logic [DW-1:0] BaseIn,
  input  logic [3:0]    BaseReg,
  output logic [3:0]    RfRdSel,
  input  logic [DW-1:0] RfRdData,
  output logic [3:0]    RfWrSel,
  output logic [DW-1:0] RfWrData,
  output logic          RfLd,
  output logic          MemReq,
  output logic          MemWr,
  output logic [DW-1:0] MemAddr,
  output logic [DW-1:0] MemWrData,
  input  logic [DW-1:0] MemRdData,
  input  logic          MemAck,
  output logic          Busy,
  output logic          Done
);

  localparam logic [DW-1:0] STEP_W = DW'(STEP);

`ifdef MREG_WRITEBACK_EN
  typedef enum logic [2:0] {IDLE, REQ, LWR, WB, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, LWR, DONE} state_t;
`endif

  function automatic logic [3:0] lowest_bit(input logic [15:0] m);
    lowest_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_bit = 4'(i);
    end
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] m);
    popcount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      popcount = popcount + 5'(m[i]);
    end
  endfunction

  state_t        state_q;
  logic          is_load_q;
  logic [15:0]   rem_q;        // listed registers still pending, current one excluded
  logic [3:0]    cur_q;        // register being transferred
  logic [DW-1:0] addr_q;
  logic          mem_req_q;
  logic          mem_wr_q;
  logic          rf_ld_q;
  logic [3:0]    rf_wr_sel_q;
  logic [DW-1:0] rf_wr_data_q;
  logic          busy_q;
  logic          done_q;

  logic [4:0]    start_n;
  logic [DW-1:0] span;
  logic [DW-1:0] start_addr;
  logic [3:0]    next_cur;

  assign start_n    = popcount(RegList);
  assign span       = STEP_W * DW'(start_n);
  // Decrement-before still transfers in ascending order: it starts at the
  // lowest address of the block and walks upward.
  assign start_addr = Up ? BaseIn : BaseIn - span;
  assign next_cur   = lowest_bit(rem_q);

`ifdef MREG_WRITEBACK_EN
  logic [3:0]    base_reg_q;
  logic [DW-1:0] wb_val_q;
  logic          wb_en_q;
  logic [DW-1:0] wb_val;
  logic          wb_en;

  assign wb_val = Up ? BaseIn + span : BaseIn - span;
  // A load that includes the base register keeps the loaded value.
  assign wb_en  = (start_n != 5'd0) && !(IsLoad && RegList[BaseReg]);
`else
  logic unused_base_reg;
  assign unused_base_reg = ^BaseReg;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      rem_q        <= 16'd0;
      cur_q        <= 4'd0;
      addr_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      rf_ld_q      <= 1'b0;
      rf_wr_sel_q  <= 4'd0;
      rf_wr_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MREG_WRITEBACK_EN
      base_reg_q   <= 4'd0;
      wb_val_q     <= '0;
      wb_en_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            is_load_q <= IsLoad;
            mem_wr_q  <= !IsLoad;
            busy_q    <= 1'b1;
            addr_q    <= start_addr;
            cur_q     <= lowest_bit(RegList);
            rem_q     <= RegList & (RegList - 16'd1);  // drop the lowest set bit
`ifdef MREG_WRITEBACK_EN
            base_reg_q <= BaseReg;
            wb_val_q   <= wb_val;
            wb_en_q    <= wb_en;
`endif
            if (RegList == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end
          end
        end

        // Address, select and direction are registers, so they hold steady
        // through any number of wait cycles until the acknowledge edge.
        REQ: begin
          if (MemAck) begin
            addr_q <= addr_q + STEP_W;
            if (is_load_q) begin
              state_q      <= LWR;
              mem_req_q    <= 1'b0;
              rf_ld_q      <= 1'b1;
              rf_wr_sel_q  <= cur_q;
              rf_wr_data_q <= MemRdData;
            end else if (rem_q != 16'd0) begin
              // Back-to-back stores: MemReq stays high, one register per cycle.
              cur_q <= next_cur;
              rem_q <= rem_q & (rem_q - 16'd1);
            end else begin
              mem_req_q <= 1'b0;
`ifdef MREG_WRITEBACK_EN
              if (wb_en_q) begin
                state_q      <= WB;
                rf_ld_q      <= 1'b1;
                rf_wr_sel_q  <= base_reg_q;
                rf_wr_data_q <= wb_val_q;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
`else
              state_q <= DONE;
              done_q  <= 1'b1;
`endif
            end
          end
        end

        LWR: begin
          rf_ld_q <= 1'b0;
          if (rem_q != 16'd0) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            cur_q     <= next_cur;
            rem_q     <= rem_q & (rem_q - 16'd1);
          end else begin
`ifdef MREG_WRITEBACK_EN
            if (wb_en_q) begin
              state_q      <= WB;
              rf_ld_q      <= 1'b1;
              rf_wr_sel_q  <= base_reg_q;
              rf_wr_data_q <= wb_val_q;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end
        end

`ifdef MREG_WRITEBACK_EN
        WB: begin
          rf_ld_q <= 1'b0;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
`endif

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          rf_ld_q   <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign RfRdSel   = cur_q;
  assign RfWrSel   = rf_wr_sel_q;
  assign RfWrData  = rf_wr_data_q;
  assign RfLd      = rf_ld_q;
  assign MemReq    = mem_req_q;
  assign MemWr     = mem_wr_q;
  assign MemAddr   = addr_q;
  assign MemWrData = RfRdData;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_regfile_mreg_sequencer.sv
// tb/tb_regfile_mreg_sequencer.sv - self-checking bench for regfile_mreg_sequencer

module tb_regfile_mreg_sequencer;

  logic        Clk, Reset_n, Start, IsLoad, Up;
  logic [15:0] RegList;
  logic [31:0] BaseIn;
  logic [3:0]  BaseReg;
  logic [3:0]  RfRdSel, RfWrSel;
  logic [31:0] RfRdData, RfWrData, MemAddr, MemWrData, MemRdData;
  logic        RfLd, MemReq, MemWr, MemAck, Busy, Done;

  regfile_mreg_sequencer #(.DW(32), .STEP(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .IsLoad(IsLoad), .Up(Up),
    .RegList(RegList), .BaseIn(BaseIn), .BaseReg(BaseReg),
    .RfRdSel(RfRdSel), .RfRdData(RfRdData), .RfWrSel(RfWrSel), .RfWrData(RfWrData),
    .RfLd(RfLd), .MemReq(MemReq), .MemWr(MemWr), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdData(MemRdData), .MemAck(MemAck),
    .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Environment: register file and memory responder
  logic [31:0] regs [16];
  bit          r_init;
  always @(posedge Clk) begin
    if (!r_init) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'(100 + 4 * i);
      r_init <= 1'b1;
    end else if (RfLd) begin
      regs[RfWrSel] <= RfWrData;
    end
  end
  assign RfRdData = regs[RfRdSel];

  int wait_cfg = 0;
  int wait_left = 0;
  always @(posedge Clk) begin
    if (!MemReq || MemAck) wait_left <= wait_cfg;
    else                   wait_left <= wait_left - 1;
  end
  assign MemAck = MemReq && (wait_left == 0);

  logic [31:0] ld_data [16];
  int          ld_idx = 0;
  always @(posedge Clk) begin
    if (Start && !Busy)                 ld_idx <= 0;
    else if (MemReq && MemAck && !MemWr) ld_idx <= ld_idx + 1;
  end
  assign MemRdData = ld_data[ld_idx];

  // Behavioural model: expected access lists built from the register list
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; logic [3:0] sel; } mem_t;
  typedef struct { logic [3:0] sel; logic [31:0] data; } wr_t;

  mem_t        exp_mem [$];
  wr_t         exp_wr  [$];
  logic [31:0] obs_addr [$];
  logic [31:0] obs_wd   [$];
  logic [31:0] model_regs [16];
  bit          m_init;
  int          m_state = 0;      // 0 idle, 1 transfer running, 2 done just seen
  int          req_cycles, ld_cycles, cyc, done_lat, done_count = 0, tot_ld = 0;
  logic        prev_req, prev_ack, prev_wr;
  logic [31:0] prev_addr;
  logic [3:0]  prev_sel;

  task automatic predict();
    int n, k;
    logic [31:0] a, span;
    n = $countones(RegList);
    span = 32'(4 * n);
    a = Up ? BaseIn : BaseIn - span;
    k = 0;
    exp_mem.delete(); exp_wr.delete(); obs_addr.delete(); obs_wd.delete();
    for (int i = 0; i < 16; i++) begin
      if (RegList[i]) begin
        exp_mem.push_back('{addr: a, wr: !IsLoad, data: model_regs[i], sel: 4'(i)});
        if (IsLoad) exp_wr.push_back('{sel: 4'(i), data: ld_data[k]});
        a = a + 32'd4;
        k++;
      end
    end
`ifdef MREG_WRITEBACK_EN
    if (n != 0 && !(IsLoad && RegList[BaseReg]))
      exp_wr.push_back('{sel: BaseReg, data: Up ? BaseIn + span : BaseIn - span});
`endif
    req_cycles = 0; ld_cycles = 0; cyc = 0;
  endtask

  always @(negedge Clk) begin : cmp
    mem_t me;
    wr_t  we;
    if (!m_init) begin
      for (int i = 0; i < 16; i++) model_regs[i] = 32'(100 + 4 * i);
      m_init = 1'b1;
    end
    if (!Reset_n) begin
      exp_mem.delete(); exp_wr.delete();
      m_state = 0; prev_req = 1'b0; prev_ack = 1'b0;
    end else begin
      if (m_state == 2) m_state = 0;
      chk("busy", Busy, (m_state != 0));
      if (prev_req && !prev_ack) begin
        chk("hold_req", MemReq, 1);
        chk("hold_addr", MemAddr, prev_addr);
        chk("hold_sel", RfRdSel, prev_sel);
        chk("hold_wr", MemWr, prev_wr);
      end
      if (MemReq) req_cycles++;
      if (MemReq && MemAck) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          me = exp_mem.pop_front();
          chk("mem_addr", MemAddr, me.addr);
          chk("mem_wr", MemWr, me.wr);
          chk("rd_sel", RfRdSel, me.sel);
          if (me.wr) chk("mem_wdata", MemWrData, me.data);
          obs_addr.push_back(MemAddr);
          obs_wd.push_back(MemWrData);
        end
      end
      if (RfLd) begin
        ld_cycles++; tot_ld++;
        if (exp_wr.size() == 0) chk("rfld_unexpected", 1, 0);
        else begin
          we = exp_wr.pop_front();
          chk("wr_sel", RfWrSel, we.sel);
          chk("wr_data", RfWrData, we.data);
          model_regs[we.sel] = we.data;
        end
      end
      if (m_state == 1) cyc++;
      if (Done) begin
        chk("done_expected", (m_state == 1), 1);
        chk("done_mem_left", exp_mem.size(), 0);
        chk("done_wr_left", exp_wr.size(), 0);
        done_lat = cyc;
        done_count++;
        m_state = 2;
      end
      if (Start && m_state == 0) begin
        predict();
        m_state = 1;
      end
      prev_req = MemReq; prev_ack = MemAck; prev_wr = MemWr;
      prev_addr = MemAddr; prev_sel = RfRdSel;
    end
  end

  // Stimulus
  int done_mark;

  task automatic xfer(input logic ld, input logic up, input logic [15:0] list,
                      input logic [31:0] base, input logic [3:0] breg);
    @(posedge Clk); #1;
    done_mark = done_count;
    IsLoad = ld; Up = up; RegList = list; BaseIn = base; BaseReg = breg; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_count == done_mark && t < 300) begin
      @(posedge Clk);
      t++;
    end
    chk({name, "_done_seen"}, (t < 300), 1);
    @(posedge Clk); #1;
  endtask

  int ld_mark;

  initial begin
    Reset_n = 1'b0; Start = 1'b0; IsLoad = 1'b0; Up = 1'b1;
    RegList = 16'd0; BaseIn = 32'd0; BaseReg = 4'd0;
    for (int i = 0; i < 16; i++) ld_data[i] = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_memreq", MemReq, 0);
    chk("rst_memwr", MemWr, 0);
    chk("rst_rfld", RfLd, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_rdsel", RfRdSel, 0);
    chk("rst_wrsel", RfWrSel, 0);
    chk("rst_wrdata", RfWrData, 0);
    chk("rst_addr", MemAddr, 0);
    Reset_n = 1'b1;

    // STM IA R0,R2
    xfer(1'b0, 1'b1, 16'h0005, 32'h100, 4'd0);
    wait_done("stm_ia");
    chk("stm_addr0", obs_addr[0], 32'h100);
    chk("stm_addr1", obs_addr[1], 32'h104);
    chk("stm_wd0", obs_wd[0], 32'd100);
    chk("stm_wd1", obs_wd[1], 32'd108);
    chk("stm_req_cycles", req_cycles, 2);
    chk("stm_latency", done_lat, 3);

    // LDM DB R0,R15
    ld_data[0] = 32'd35; ld_data[1] = 32'd40;
    xfer(1'b1, 1'b0, 16'h8001, 32'h200, 4'd0);
    wait_done("ldm_db");
    chk("ldm_addr0", obs_addr[0], 32'h1F8);
    chk("ldm_addr1", obs_addr[1], 32'h1FC);
    chk("ldm_r0", regs[0], 32'd35);
    chk("ldm_r15", regs[15], 32'd40);
    chk("ldm_ld_cycles", ld_cycles, 2);
    chk("ldm_latency", done_lat, 5);

    // Wait states on STM R4, with a Start pulse while busy
    wait_cfg = 3;
    xfer(1'b0, 1'b1, 16'h0010, 32'h500, 4'd0);
    IsLoad = 1'b1; RegList = 16'hFFFF; BaseIn = 32'h9000; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done("wait");
    wait_cfg = 0;
    chk("wait_req_cycles", req_cycles, 4);
    chk("wait_addr", obs_addr[0], 32'h500);
    chk("wait_wd", obs_wd[0], 32'd116);
    chk("wait_latency", done_lat, 5);

    // Empty list
    xfer(1'b1, 1'b1, 16'h0000, 32'h700, 4'd0);
    wait_done("empty");
    chk("empty_latency", done_lat, 1);
    chk("empty_req", req_cycles, 0);
    chk("empty_ld", ld_cycles, 0);

    // DB from address 0 wraps
    xfer(1'b0, 1'b0, 16'h0003, 32'h0, 4'd0);
    wait_done("wrap");
    chk("wrap_addr0", obs_addr[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", obs_addr[1], 32'hFFFF_FFFC);

    // Reset in the middle of an LDM request
    wait_cfg = 20;
    xfer(1'b1, 1'b1, 16'h0003, 32'h300, 4'd0);
    @(posedge Clk); #1;
    chk("mid_pre_req", MemReq, 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_memreq", MemReq, 0);
    chk("mid_rfld", RfLd, 0);
    chk("mid_busy", Busy, 0);
    chk("mid_done", Done, 0);
    ld_mark = tot_ld;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    wait_cfg = 0;
    repeat (6) @(posedge Clk);
    #1;
    chk("mid_no_write", tot_ld, ld_mark);
    chk("mid_idle", Busy, 0);

`ifdef MREG_WRITEBACK_EN
    xfer(1'b0, 1'b1, 16'h000F, 32'h40, 4'd13);
    wait_done("wb_stm");
    chk("wb_r13", regs[13], 32'h50);
    chk("wb_addr3", obs_addr[3], 32'h4C);
    ld_data[0] = 32'd77;
    xfer(1'b1, 1'b1, 16'h2000, 32'h80, 4'd13);
    wait_done("wb_ldm");
    chk("wb_skip_r13", regs[13], 32'd77);
    chk("wb_skip_ld", ld_cycles, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mreg_sequencer.md
Name: regfile_mreg_sequencer

Overview:
- Controller for the 16x32 register file (two combinational read ports, one clocked write port gated by Ld) that executes ARM-style multiple-register transfers (LDM/STM).
- Walks a 16-bit register list in ascending register order. Drives the register-file read select (store) or write select/data/Ld (load), and runs a req/ack handshake with memory.
- Sits between the decode/control unit and the register file's port-B read and C write inputs.

Parameters:
- DW, 32, data and address width.
- STEP, 4, byte increment per transferred word.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  launch a transfer; sampled only in IDLE.
- IsLoad  in  1  1 = LDM (mem to regs), 0 = STM (regs to mem); captured on Start.
- Up  in  1  1 = increment-after (IA), 0 = decrement-before (DB); captured on Start.
- RegList  in  16  bit i set means register Ri transfers; captured on Start.
- BaseIn  in  DW  base address; captured on Start.
- BaseReg  in  4  base register number, used only by the optional feature; captured on Start.
- RfRdSel  out  4  register-file read select for stores (drives regB).
- RfRdData  in  DW  register-file read data (port B), combinational from RfRdSel.
- RfWrSel  out  4  register-file write select (drives deC).
- RfWrData  out  DW  register-file write data (drives C).
- RfLd  out  1  register-file write enable (drives Ld).
- MemReq  out  1  memory request.
- MemWr  out  1  1 = write, 0 = read; valid while MemReq = 1.
- MemAddr  out  DW  word address.
- MemWrData  out  DW  store data; equals RfRdData.
- MemRdData  in  DW  load data; valid when MemAck = 1.
- MemAck  in  1  completes the request on the edge where MemReq and MemAck are both 1.
- Busy  out  1  1 in every state except IDLE.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, Reset_n = 0): state goes to IDLE. All outputs are 0: RfLd, MemReq, MemWr, Busy, Done, RfRdSel, RfWrSel, RfWrData and MemAddr. Any in-flight transfer is abandoned and no further RfLd is issued.
- States: IDLE, REQ, LWR, WB (optional feature only), DONE.
- IDLE:
  - Start = 1 captures all inputs and computes N = popcount(RegList).
  - Start address: BaseIn for IA; BaseIn - STEP*N for DB.
  - N = 0 goes to DONE; otherwise goes to REQ with the lowest set bit as the current register.
  - Start while Busy is ignored.
- REQ:
  - MemReq = 1, MemAddr = current address, MemWr = !IsLoad, RfRdSel = current register.
  - All of these stay stable until MemAck is sampled at 1.
  - On ack, the address advances by STEP.
  - Store: go to the next set bit, or to the end state if this was the last register.
  - Load: capture MemRdData and go to LWR.
- LWR: RfLd = 1 for exactly one cycle, RfWrSel = current register, RfWrData = captured data. Then go to REQ for the next register, or to the end state.
- End state: WB if the optional feature is enabled, otherwise DONE.
- DONE: Done = 1 and Busy = 1 for one cycle, then IDLE. A Start can be accepted on the following cycle.
- Throughput with MemAck tied to 1: stores take 1 cycle per register; loads take 2 cycles per register.
- Addresses: arithmetic is modulo 2^DW with no alignment forcing. DB with 0x0 base wraps to high addresses.
- Register order: always ascending, so R15 is the last register transferred.

Optional Feature:
- Macro MREG_WRITEBACK_EN.
- Defined:
  - After the last transfer, go to WB. WB drives RfLd = 1 for one cycle, RfWrSel = BaseReg, RfWrData = BaseIn + STEP*N (IA) or BaseIn - STEP*N (DB). Then go to DONE.
  - WB is skipped (direct to DONE) when IsLoad = 1 and RegList[BaseReg] = 1, so the loaded value wins.
  - WB is also skipped when N = 0.
- Not defined: no WB state, BaseReg is ignored, and the base register is never written.

Test Plan:
- Reset: Reset_n = 0 mid-LDM with MemReq = 1 -> MemReq, RfLd, Busy and Done are 0 immediately; after release with no Start, no register writes occur.
- STM IA: RegList = 16'h0005, BaseIn = 0x100, R0 = 100, R2 = 108, MemAck = 1 -> two MemReq cycles at 0x100/0x104, MemWrData 100/108, RfRdSel 0/2, MemWr = 1, then Done pulse.
- LDM DB: RegList = 16'h8001, BaseIn = 0x200, MemRdData 35 then 40 -> MemAddr 0x1F8 then 0x1FC; RfLd pulses write R0 = 35 then R15 = 40; Done follows.
- Wait states: MemAck = 0 for 3 cycles during STM of R4 -> MemReq, MemAddr and RfRdSel are stable for 4 cycles; a Start pulse while Busy has no effect.
- Empty list: RegList = 0 -> Done one cycle after Start; MemReq and RfLd stay 0 throughout.
- MREG_WRITEBACK_EN: STM IA RegList = 16'h000F, BaseIn = 0x40, BaseReg = 13 -> R13 written 0x50 before Done. LDM with RegList[13] = 1 -> no WB write.
